// File: rtl/cbx_pkg.sv
// Shared definitions for the X-channel connection block: configuration FSM
// states, select-width sizing and tap placement along the channel.
package cbx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EVAL  = 2'd2
  } cfg_state_t;

  // One extra code beyond the 2*FANIN inputs keeps the all-ones code free,
  // so it can always mean "disconnected".
  function automatic int sel_bits(input int fanin);
    return $clog2(2 * fanin + 1);
  endfunction

  function automatic int tap_index(input int i, input int t, input int stride,
                                   input int width);
    return (i + t * stride) % width;
  endfunction

endpackage

// File: rtl/cbx_ipin_mux.sv
// Per-pin routing mux: selects one of 2*FANIN tap bits, or drives 0 for any
// select code outside the valid input range.
module cbx_ipin_mux #(
  parameter int FANIN    = 5,
  parameter int SEL_BITS = 4
) (
  input  logic [2*FANIN-1:0] data,
  input  logic [SEL_BITS-1:0] sel,
  output logic                out
);

  always_comb begin
    out = 1'b0;
    for (int j = 0; j < 2 * FANIN; j++) begin
      if (sel == SEL_BITS'(j)) out = data[j];
    end
  end

endmodule

// File: rtl/cbx_param_shadow.sv
// X-channel connection block with a shadowed scan-chain configuration: bits
// shift into a shadow register and are committed atomically to the mux selects.
module cbx_param_shadow
  import cbx_pkg::*;
#(
  parameter int CHAN_WIDTH = 20,
  parameter int NUM_IPIN   = 12,
  parameter int FANIN      = 5,
  parameter int TAP_STRIDE = 4
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  config_enable,
  input  logic                  ccff_head,
  input  logic [CHAN_WIDTH-1:0] chanx_left_in,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  output logic [CHAN_WIDTH-1:0] chanx_left_out,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  output logic [NUM_IPIN-1:0]   ipin_out,
  output logic                  ccff_tail,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  localparam int SEL_BITS   = sel_bits(FANIN);
  localparam int TOTAL_BITS = NUM_IPIN * SEL_BITS;
  localparam int CNT_W      = $clog2(TOTAL_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(TOTAL_BITS + 1);

  logic [TOTAL_BITS-1:0] shadow;
  logic [TOTAL_BITS-1:0] active;
  logic [CNT_W-1:0]      bit_cnt;
  cfg_state_t            state;
  logic                  shift_en;

  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;
  assign ccff_tail       = shadow[TOTAL_BITS-1];

  // The EVAL cycle deliberately drops any enable so the length judged is stable.
  assign shift_en = config_enable && (state != EVAL);

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shadow   <= '0;
      active   <= '1;
      bit_cnt  <= '0;
      state    <= IDLE;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (shift_en) shadow <= {shadow[TOTAL_BITS-2:0], ccff_head};
      case (state)
        IDLE: begin
          if (config_enable) begin
            state   <= SHIFT;
            bit_cnt <= CNT_ONE;
          end
        end
        SHIFT: begin
          if (config_enable) begin
            if (bit_cnt != CNT_OVER) bit_cnt <= bit_cnt + CNT_ONE;
          end else begin
            state <= EVAL;
          end
        end
        EVAL: begin
          if (bit_cnt == CNT_FULL) begin
            active   <= shadow;
            cfg_done <= 1'b1;
            cfg_err  <= 1'b0;
          end else begin
            cfg_err <= 1'b1;
          end
          bit_cnt <= '0;
          state   <= IDLE;
        end
        default: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Pin 0 occupies the MSB field of the active register.
  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_pin
    logic [2*FANIN-1:0] taps;
    for (genvar t = 0; t < FANIN; t++) begin : g_tap
      localparam int K = tap_index(i, t, TAP_STRIDE, CHAN_WIDTH);
      assign taps[2*t]   = chanx_left_in[K];
      assign taps[2*t+1] = chanx_right_in[K];
    end
    cbx_ipin_mux #(
      .FANIN    (FANIN),
      .SEL_BITS (SEL_BITS)
    ) u_mux (
      .data (taps),
      .sel  (active[TOTAL_BITS-1-i*SEL_BITS -: SEL_BITS]),
      .out  (ipin_out[i])
    );
  end

endmodule
